// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if: writeback/decode-side bundle for the integer register file
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] wR;
    logic [DATA_W-1:0] wD;
    logic [ADDR_W-1:0] rR1;
    logic [ADDR_W-1:0] rR2;
    logic              rs1_used;
    logic              rs2_used;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_rd;
    logic [DATA_W-1:0] rD1;
    logic [DATA_W-1:0] rD2;
    logic              stall;
    logic [ADDR_W:0]   busy_cnt;
    modport master (
        output we, wR, wD, rR1, rR2, rs1_used, rs2_used, busy_set, busy_rd,
        input  rD1, rD2, stall, busy_cnt
    );
    modport slave (
        input  we, wR, wD, rR1, rR2, rs1_used, rs2_used, busy_set, busy_rd,
        output rD1, rD2, stall, busy_cnt
    );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb: register file with write bypass and pending-write scoreboard
module reg_file_wb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input logic          clk,
    input logic          rst,
    reg_file_wb_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr, set, byp1, byp2;
    always_comb begin
        wr     = bus.we && bus.wR != '0;
        set    = bus.busy_set && bus.busy_rd != '0;
        byp1   = BYPASS && bus.we && bus.wR == bus.rR1;
        byp2   = BYPASS && bus.we && bus.wR == bus.rR2;
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr) begin
            regs_d[bus.wR] = bus.wD;
            busy_d[bus.wR] = 1'b0;
        end
        // a new producer supersedes the one retiring this cycle
        if (set)
            busy_d[bus.busy_rd] = 1'b1;
        cnt_d = '0;
        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        bus.rD1      = bus.rR1 == '0 ? '0 : byp1 ? bus.wD : regs_q[bus.rR1];
        bus.rD2      = bus.rR2 == '0 ? '0 : byp2 ? bus.wD : regs_q[bus.rR2];
        bus.stall    = (bus.rs1_used && bus.rR1 != '0 && busy_q[bus.rR1] && !byp1) ||
                       (bus.rs2_used && bus.rR2 != '0 && busy_q[bus.rR2] && !byp2);
        bus.busy_cnt = cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: directed checks of a bypassing and a non-bypassing register file
module tb_reg_file_wb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) b1 ();
    reg_file_wb_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) d1 (.clk(clk), .rst(rst), .bus(b1));
    reg_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) d0 (.clk(clk), .rst(rst), .bus(b0));
    assign b0.we       = b1.we;
    assign b0.wR       = b1.wR;
    assign b0.wD       = b1.wD;
    assign b0.rR1      = b1.rR1;
    assign b0.rR2      = b1.rR2;
    assign b0.rs1_used = b1.rs1_used;
    assign b0.rs2_used = b1.rs2_used;
    assign b0.busy_set = b1.busy_set;
    assign b0.busy_rd  = b1.busy_rd;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        b1.we = 1'b0; b1.wR = '0; b1.wD = '0;
        b1.rR1 = '0; b1.rR2 = '0; b1.rs1_used = 1'b0; b1.rs2_used = 1'b0;
        b1.busy_set = 1'b0; b1.busy_rd = '0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        #3;
        chk("rst_cnt", 32'(b1.busy_cnt), 0);
        chk("rst_stall", 32'(b1.stall), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            b1.rR1 = 5'(i); b1.rR2 = 5'(31 - i); b1.rs1_used = 1'b1; b1.rs2_used = 1'b1;
            #1;
            chk("init_rd1", b1.rD1, 0);
            chk("init_rd2", b1.rD2, 0);
            chk("init_rd1_nb", b0.rD1, 0);
            chk("init_stall", 32'(b1.stall), 0);
        end
        chk("init_cnt", 32'(b1.busy_cnt), 0);
        edge_step();
        b1.we = 1'b1; b1.wR = 5'd5; b1.wD = 32'hDEADBEEF;
        edge_step();
        b1.rR1 = 5'd5;
        #1;
        chk("x5_rd", b1.rD1, 32'hDEADBEEF);
        chk("x5_rd_nb", b0.rD1, 32'hDEADBEEF);
        b1.we = 1'b1; b1.wR = 5'd5; b1.wD = 32'h12345678;
        #1;
        chk("x5_bypass", b1.rD1, 32'h12345678);
        chk("x5_nobypass", b0.rD1, 32'hDEADBEEF);
        edge_step();
        b1.rR1 = 5'd5;
        #1;
        chk("x5_new_nb", b0.rD1, 32'h12345678);
        b1.we = 1'b1; b1.wR = 5'd0; b1.wD = 32'hFFFFFFFF; b1.rR1 = 5'd0;
        b1.busy_set = 1'b1; b1.busy_rd = 5'd0;
        #1;
        chk("x0_bypass", b1.rD1, 0);
        edge_step();
        b1.rR1 = 5'd0;
        #1;
        chk("x0_after", b1.rD1, 0);
        chk("x0_busy_cnt", 32'(b1.busy_cnt), 0);
        b1.busy_set = 1'b1; b1.busy_rd = 5'd7;
        #1;
        chk("set_same_cycle_stall", 32'(b1.stall), 0);
        edge_step();
        b1.rR2 = 5'd7; b1.rs2_used = 1'b1;
        #1;
        chk("x7_stall", 32'(b1.stall), 1);
        chk("x7_stall_nb", 32'(b0.stall), 1);
        chk("x7_cnt", 32'(b1.busy_cnt), 1);
        b1.rs2_used = 1'b0;
        #1;
        chk("x7_unused", 32'(b1.stall), 0);
        b1.rs2_used = 1'b1; b1.we = 1'b1; b1.wR = 5'd7; b1.wD = 32'h55;
        #1;
        chk("x7_clear_stall", 32'(b1.stall), 0);
        chk("x7_clear_stall_nb", 32'(b0.stall), 1);
        chk("x7_clear_rd2", b1.rD2, 32'h55);
        chk("x7_clear_rd2_nb", b0.rD2, 0);
        edge_step();
        b1.rR2 = 5'd7; b1.rs2_used = 1'b1;
        #1;
        chk("x7_cnt_after", 32'(b1.busy_cnt), 0);
        chk("x7_stall_after", 32'(b1.stall), 0);
        chk("x7_rd2_after", b1.rD2, 32'h55);
        b1.busy_set = 1'b1; b1.busy_rd = 5'd9;
        edge_step();
        b1.busy_set = 1'b1; b1.busy_rd = 5'd9;
        edge_step();
        chk("x9_dup_set_cnt", 32'(b1.busy_cnt), 1);
        b1.busy_set = 1'b1; b1.busy_rd = 5'd9; b1.we = 1'b1; b1.wR = 5'd9; b1.wD = 32'h99;
        edge_step();
        b1.rR1 = 5'd9; b1.rs1_used = 1'b1;
        #1;
        chk("x9_setwins_cnt", 32'(b1.busy_cnt), 1);
        chk("x9_setwins_stall", 32'(b1.stall), 1);
        chk("x9_data", b1.rD1, 32'h99);
        b1.we = 1'b1; b1.wR = 5'd9; b1.wD = 32'h9A;
        edge_step();
        chk("x9_cleared_cnt", 32'(b1.busy_cnt), 0);
        b1.we = 1'b1; b1.wR = 5'd10; b1.wD = 32'hA;
        edge_step();
        chk("nonbusy_clear_cnt", 32'(b1.busy_cnt), 0);
        b1.busy_set = 1'b1; b1.busy_rd = 5'd3;
        edge_step();
        b1.busy_set = 1'b1; b1.busy_rd = 5'd4;
        edge_step();
        b1.rR1 = 5'd3; b1.rR2 = 5'd5; b1.rs1_used = 1'b1; b1.rs2_used = 1'b1;
        b1.busy_set = 1'b1; b1.busy_rd = 5'd12; b1.we = 1'b1; b1.wR = 5'd6; b1.wD = 32'h66;
        #1;
        chk("x34_cnt", 32'(b1.busy_cnt), 2);
        chk("x34_stall", 32'(b1.stall), 1);
        chk("x5_before_rst", b1.rD2, 32'h12345678);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_cnt", 32'(b1.busy_cnt), 0);
        chk("midrst_stall", 32'(b1.stall), 0);
        chk("midrst_rd2", b1.rD2, 0);
        chk("midrst_cnt_nb", 32'(b0.busy_cnt), 0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        b1.rR1 = 5'd6; b1.rR2 = 5'd9;
        #1;
        chk("postrst_x6", b1.rD1, 0);
        chk("postrst_x9", b1.rD2, 0);
        edge_step();
        chk("postrst_cnt", 32'(b1.busy_cnt), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
